// File: rtl/prediction_update_unit.sv
// Resolution-side tracker for local-history branch prediction: in-flight queue, per-index history/tags, table write-back.
// Optional PRED_STATS_EN adds saturating branch/mispredict counters on stat_branches/stat_mispredicts.
module prediction_update_unit #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 10,
    parameter int INDEX_WIDTH = 4,
    parameter int HIST_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    input  logic [PC_WIDTH-1:0]          fetch_pc,
    input  logic                         fetch_pred,
    output logic                         fetch_ready,
    output logic [HIST_WIDTH-1:0]        cur_history,
    output logic                         fetch_evict,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic                         flush,
    output logic                         upd_we,
    output logic [PC_WIDTH-1:0]          upd_pc,
    output logic [HIST_WIDTH-1:0]        upd_history,
    output logic                         upd_taken,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  stat_branches,
    output logic [15:0]                  stat_mispredicts
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TAG_W = PC_WIDTH - INDEX_WIDTH;
    localparam int N_IDX = 1 << INDEX_WIDTH;

    logic [PC_WIDTH-1:0]    q_pc   [DEPTH];
    logic [HIST_WIDTH-1:0]  q_hist [DEPTH];
    logic                   q_pred [DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [OCC_W-1:0]       count_q;

    logic [HIST_WIDTH-1:0]  hist_q [N_IDX];
    logic [TAG_W-1:0]       tag_q  [N_IDX];
    logic [N_IDX-1:0]       tag_vld_q;

    logic                   vld_p1;
    logic [PC_WIDTH-1:0]    pc_p1;
    logic [HIST_WIDTH-1:0]  hist_p1;
    logic                   taken_p1;
    logic                   mis_p1;

    logic [INDEX_WIDTH-1:0] fetch_idx;
    logic [TAG_W-1:0]       fetch_tag;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [INDEX_WIDTH-1:0] head_idx;
    logic                   push;
    logic                   pop;
    logic                   mis;
    logic                   kill;

    // Stage p0: fetch lookup and resolve decode
    assign fetch_idx   = fetch_pc[INDEX_WIDTH-1:0];
    assign fetch_tag   = fetch_pc[PC_WIDTH-1:INDEX_WIDTH];
    assign fetch_evict = fetch_valid & (~tag_vld_q[fetch_idx] | (tag_q[fetch_idx] != fetch_tag));
    assign cur_history = fetch_evict ? '0 : hist_q[fetch_idx];
    // No pass-through: a same-cycle pop does not free a slot for the fetch.
    assign fetch_ready = (count_q < OCC_W'(DEPTH));
    assign occupancy   = count_q;

    assign push     = fetch_valid & fetch_ready;
    assign pop      = resolve_valid & (count_q != '0);
    assign head_pc  = q_pc[head_q];
    assign head_idx = head_pc[INDEX_WIDTH-1:0];
    assign mis      = pop & (q_pred[head_q] != resolve_taken);
    assign kill     = flush | mis;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail_q]   <= fetch_pc;
            q_hist[tail_q] <= cur_history;
            q_pred[tail_q] <= fetch_pred;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (kill) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && fetch_evict) tag_q[fetch_idx] <= fetch_tag;
    end

    // Evict clear is written last so it wins over a same-index resolve shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_IDX; i++) hist_q[i] <= '0;
            tag_vld_q <= '0;
        end else begin
            if (pop) hist_q[head_idx] <= {hist_q[head_idx][HIST_WIDTH-2:0], resolve_taken};
            if (push && fetch_evict) begin
                hist_q[fetch_idx]    <= '0;
                tag_vld_q[fetch_idx] <= 1'b1;
            end
        end
    end

    // Stage p1: registered table write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            mis_p1   <= 1'b0;
            pc_p1    <= '0;
            hist_p1  <= '0;
            taken_p1 <= 1'b0;
        end else begin
            vld_p1 <= pop;
            mis_p1 <= mis;
            if (pop) begin
                pc_p1    <= head_pc;
                hist_p1  <= q_hist[head_q];
                taken_p1 <= resolve_taken;
            end
        end
    end

    assign upd_we      = vld_p1;
    assign upd_pc      = pc_p1;
    assign upd_history = hist_p1;
    assign upd_taken   = taken_p1;
    assign mispredict  = mis_p1;

`ifdef PRED_STATS_EN
    logic [15:0] stat_br_q;
    logic [15:0] stat_mp_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (pop) stat_br_q <= sat_inc(stat_br_q);
            if (mis) stat_mp_q <= sat_inc(stat_mp_q);
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_prediction_update_unit.sv
// Bench for prediction_update_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_prediction_update_unit;

    localparam int DEPTH       = 4;
    localparam int PC_WIDTH    = 10;
    localparam int INDEX_WIDTH = 4;
    localparam int HIST_WIDTH  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid, fetch_pred, resolve_valid, resolve_taken, flush;
    logic [9:0]  fetch_pc;
    logic        fetch_ready, fetch_evict, upd_we, upd_taken, mispredict;
    logic [2:0]  cur_history, upd_history, occupancy;
    logic [9:0]  upd_pc;
    logic [15:0] stat_branches, stat_mispredicts;

    prediction_update_unit #(
        .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .HIST_WIDTH(HIST_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
        .fetch_ready(fetch_ready), .cur_history(cur_history), .fetch_evict(fetch_evict),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .upd_we(upd_we), .upd_pc(upd_pc), .upd_history(upd_history), .upd_taken(upd_taken),
        .mispredict(mispredict), .occupancy(occupancy),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] pc;
        logic [2:0] hist;
        logic       pred;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] m_hist  [16];
    logic [5:0] m_tag   [16];
    logic       m_valid [16];
    logic       m_we, m_taken, m_mis;
    logic [9:0] m_pc;
    logic [2:0] m_uh;
    int         m_br, m_mp;
    int         passed = 0;
    int         total  = 0;

    function automatic logic m_evict();
        int i;
        i = int'(fetch_pc[3:0]);
        return fetch_valid && (!m_valid[i] || m_tag[i] != fetch_pc[9:4]);
    endfunction

    function automatic logic [2:0] m_cur();
        return m_evict() ? 3'd0 : m_hist[int'(fetch_pc[3:0])];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) begin
            m_hist[i] = 3'd0; m_tag[i] = 6'd0; m_valid[i] = 1'b0;
        end
        m_we = 0; m_taken = 0; m_mis = 0; m_pc = 0; m_uh = 0; m_br = 0; m_mp = 0;
    endtask

    task automatic model_clock();
        int fi, hi;
        logic ev, push, pop;
        logic [2:0] ch;
        ent_t e, n;
        fi = int'(fetch_pc[3:0]);
        ev = m_evict();
        ch = m_cur();
        push = fetch_valid && (mq.size() < DEPTH);
        pop  = resolve_valid && (mq.size() > 0);
        m_we = pop;
        m_mis = 1'b0;
        if (pop) begin
            e = mq.pop_front();
            m_pc = e.pc; m_uh = e.hist; m_taken = resolve_taken;
            m_mis = (e.pred != resolve_taken);
            hi = int'(e.pc[3:0]);
            m_hist[hi] = 3'((int'(m_hist[hi]) * 2 + int'(resolve_taken)) % 8);
            m_br++;
            if (m_mis) m_mp++;
        end
        if (push && ev) begin
            m_tag[fi] = fetch_pc[9:4]; m_valid[fi] = 1'b1; m_hist[fi] = 3'd0;
        end
        if (push) begin
            n.pc = fetch_pc; n.hist = ch; n.pred = fetch_pred;
            mq.push_back(n);
        end
        if (flush || m_mis) mq.delete();
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid = 0; fetch_pc = 10'd0; fetch_pred = 0;
        resolve_valid = 0; resolve_taken = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
    endtask

    task automatic push_one(input logic [9:0] pc, input logic pred);
        idle();
        fetch_valid = 1; fetch_pc = pc; fetch_pred = pred;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #2;
        total++; if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d exp 0", occupancy); else passed++;
        total++; if (fetch_ready !== 1'b1) $display("FAIL reset_ready: got %0b exp 1", fetch_ready); else passed++;
        total++; if (upd_we !== 1'b0) $display("FAIL reset_we: got %0b exp 0", upd_we); else passed++;
        total++; if (upd_pc !== 10'd0) $display("FAIL reset_pc: got %0h exp 0", upd_pc); else passed++;
        total++; if (upd_history !== 3'd0) $display("FAIL reset_hist: got %0h exp 0", upd_history); else passed++;
        total++; if (upd_taken !== 1'b0) $display("FAIL reset_taken: got %0b exp 0", upd_taken); else passed++;
        total++; if (mispredict !== 1'b0) $display("FAIL reset_mis: got %0b exp 0", mispredict); else passed++;
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        fetch_valid = 1; fetch_pc = 10'h013; fetch_pred = 1;
        #1;
        total++; if (fetch_evict !== 1'b1) $display("FAIL basic_evict1: got %0b exp 1", fetch_evict); else passed++;
        total++; if (cur_history !== 3'd0) $display("FAIL basic_cur1: got %0h exp 0", cur_history); else passed++;
        tick();
        idle(); resolve_valid = 1; resolve_taken = 1;
        tick();
        total++; if (upd_we !== 1'b1) $display("FAIL basic_we: got %0b exp 1", upd_we); else passed++;
        total++; if (upd_pc !== 10'h013) $display("FAIL basic_pc: got %0h exp 13", upd_pc); else passed++;
        total++; if (upd_history !== 3'd0) $display("FAIL basic_uhist: got %0h exp 0", upd_history); else passed++;
        total++; if (upd_taken !== 1'b1) $display("FAIL basic_taken: got %0b exp 1", upd_taken); else passed++;
        total++; if (mispredict !== 1'b0) $display("FAIL basic_mis: got %0b exp 0", mispredict); else passed++;
        idle(); fetch_valid = 1; fetch_pc = 10'h013; fetch_pred = 1;
        #1;
        total++; if (fetch_evict !== 1'b0) $display("FAIL basic_evict2: got %0b exp 0", fetch_evict); else passed++;
        total++; if (cur_history !== 3'b001) $display("FAIL basic_cur2: got %0h exp 1", cur_history); else passed++;
        tick();
        total++; if (upd_we !== 1'b0) $display("FAIL basic_we_drop: got %0b exp 0", upd_we); else passed++;
        total++; if (upd_pc !== 10'h013) $display("FAIL basic_pc_hold: got %0h exp 13", upd_pc); else passed++;
        idle(); fetch_valid = 1; fetch_pc = 10'h023; fetch_pred = 1;
        #1;
        total++; if (fetch_evict !== 1'b1) $display("FAIL basic_evict3: got %0b exp 1", fetch_evict); else passed++;
        total++; if (cur_history !== 3'd0) $display("FAIL basic_cur3: got %0h exp 0", cur_history); else passed++;
        tick();
        idle(); fetch_pc = 10'h013;
        #1;
        total++; if (cur_history !== 3'd0) $display("FAIL basic_cleared: got %0h exp 0", cur_history); else passed++;
        resolve_valid = 1; resolve_taken = 1;
        tick();
        total++; if (upd_pc !== 10'h013) $display("FAIL basic_pc_a: got %0h exp 13", upd_pc); else passed++;
        total++; if (upd_history !== 3'b001) $display("FAIL basic_uhist_a: got %0h exp 1", upd_history); else passed++;
        idle(); resolve_valid = 1; resolve_taken = 1;
        tick();
        total++; if (upd_pc !== 10'h023) $display("FAIL basic_pc_b: got %0h exp 23", upd_pc); else passed++;
        total++; if (upd_history !== 3'd0) $display("FAIL basic_uhist_b: got %0h exp 0", upd_history); else passed++;
        idle(); fetch_pc = 10'h023;
        #1;
        total++; if (cur_history !== 3'b011) $display("FAIL basic_shift: got %0h exp 3", cur_history); else passed++;
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1; fetch_pc = 10'(10'h040 + i); fetch_pred = 0;
            #1;
            total++; if (fetch_ready !== 1'b1) $display("FAIL full_ready%0d: got %0b exp 1", i, fetch_ready); else passed++;
            tick();
        end
        idle();
        #1;
        total++; if (fetch_ready !== 1'b0) $display("FAIL full_ready: got %0b exp 0", fetch_ready); else passed++;
        total++; if (occupancy !== 3'd4) $display("FAIL full_occ: got %0d exp 4", occupancy); else passed++;
        fetch_valid = 1; fetch_pc = 10'h050;
        tick();
        total++; if (occupancy !== 3'd4) $display("FAIL full_fifth: got %0d exp 4", occupancy); else passed++;
        idle(); fetch_valid = 1; fetch_pc = 10'h051; resolve_valid = 1; resolve_taken = 0;
        #1;
        total++; if (fetch_ready !== 1'b0) $display("FAIL full_nopass: got %0b exp 0", fetch_ready); else passed++;
        tick();
        total++; if (occupancy !== 3'd3) $display("FAIL full_popocc: got %0d exp 3", occupancy); else passed++;
        total++; if (upd_we !== 1'b1) $display("FAIL full_we: got %0b exp 1", upd_we); else passed++;
        total++; if (upd_pc !== 10'h040) $display("FAIL full_pc: got %0h exp 40", upd_pc); else passed++;
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        push_one(10'h081, 1'b0);
        push_one(10'h082, 1'b1);
        push_one(10'h083, 1'b1);
        resolve_valid = 1; resolve_taken = 1;
        tick();
        total++; if (mispredict !== 1'b1) $display("FAIL mis_pulse: got %0b exp 1", mispredict); else passed++;
        total++; if (upd_we !== 1'b1) $display("FAIL mis_we: got %0b exp 1", upd_we); else passed++;
        total++; if (upd_pc !== 10'h081) $display("FAIL mis_pc: got %0h exp 81", upd_pc); else passed++;
        total++; if (occupancy !== 3'd0) $display("FAIL mis_occ: got %0d exp 0", occupancy); else passed++;
        idle();
        tick();
        total++; if (mispredict !== 1'b0) $display("FAIL mis_end: got %0b exp 0", mispredict); else passed++;
        total++; if (upd_we !== 1'b0) $display("FAIL mis_one_we: got %0b exp 0", upd_we); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        push_one(10'h101, 1'b1);
        push_one(10'h102, 1'b0);
        flush = 1; resolve_valid = 1; resolve_taken = 1;
        fetch_valid = 1; fetch_pc = 10'h101; fetch_pred = 0;
        #1;
        total++; if (fetch_evict !== 1'b0) $display("FAIL flush_evict: got %0b exp 0", fetch_evict); else passed++;
        tick();
        total++; if (upd_we !== 1'b1) $display("FAIL flush_we: got %0b exp 1", upd_we); else passed++;
        total++; if (upd_pc !== 10'h101) $display("FAIL flush_pc: got %0h exp 101", upd_pc); else passed++;
        total++; if (mispredict !== 1'b0) $display("FAIL flush_mis: got %0b exp 0", mispredict); else passed++;
        total++; if (occupancy !== 3'd0) $display("FAIL flush_occ: got %0d exp 0", occupancy); else passed++;
        idle();
        tick();
        total++; if (upd_we !== 1'b0) $display("FAIL flush_one_we: got %0b exp 0", upd_we); else passed++;
        total++; if (occupancy !== 3'd0) $display("FAIL flush_dropped: got %0d exp 0", occupancy); else passed++;
        resolve_valid = 1; resolve_taken = 0;
        tick();
        total++; if (upd_we !== 1'b0) $display("FAIL empty_resolve_we: got %0b exp 0", upd_we); else passed++;
        total++; if (upd_pc !== 10'h101) $display("FAIL empty_resolve_pc: got %0h exp 101", upd_pc); else passed++;
        idle();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        push_one(10'h035, 1'b1);
        push_one(10'h031, 1'b0);
        fetch_valid = 1; fetch_pc = 10'h032; fetch_pred = 0;
        resolve_valid = 1; resolve_taken = 1;
        tick();
        idle(); fetch_pc = 10'h005;
        #1;
        total++; if (cur_history !== 3'b001) $display("FAIL mid_prehist: got %0h exp 1", cur_history); else passed++;
        total++; if (occupancy !== 3'd2) $display("FAIL mid_preocc: got %0d exp 2", occupancy); else passed++;
        rst = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) $display("FAIL mid_occ: got %0d exp 0", occupancy); else passed++;
        total++; if (mispredict !== 1'b0) $display("FAIL mid_mis: got %0b exp 0", mispredict); else passed++;
        total++; if (upd_we !== 1'b0) $display("FAIL mid_we: got %0b exp 0", upd_we); else passed++;
        total++; if (upd_pc !== 10'd0) $display("FAIL mid_pc: got %0h exp 0", upd_pc); else passed++;
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 10'(i);
            #1;
            total++; if (cur_history !== 3'd0) $display("FAIL mid_hist%0d: got %0h exp 0", i, cur_history); else passed++;
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            fetch_valid   = ($urandom % 2) == 0;
            fetch_pc      = 10'((($urandom % 4) << 4) | ($urandom % 4));
            fetch_pred    = ($urandom % 2) == 0;
            resolve_valid = ($urandom % 2) == 0;
            if (mq.size() > 0 && ($urandom % 5) != 0) resolve_taken = mq[0].pred;
            else resolve_taken = ($urandom % 2) == 0;
            flush = ($urandom % 16) == 0;
            if (flush) fetch_valid = 0;
            if (resolve_valid && mq.size() > 0 && mq[0].pred != resolve_taken) fetch_valid = 0;
            #1;
            total++; if (fetch_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_ready@%0d: got %0b", n, fetch_ready); else passed++;
            total++; if (fetch_evict !== m_evict()) $display("FAIL rnd_evict@%0d: got %0b exp %0b", n, fetch_evict, m_evict()); else passed++;
            total++; if (cur_history !== m_cur()) $display("FAIL rnd_cur@%0d: got %0h exp %0h", n, cur_history, m_cur()); else passed++;
            tick();
            total++; if (occupancy !== 3'(mq.size())) $display("FAIL rnd_occ@%0d: got %0d exp %0d", n, occupancy, mq.size()); else passed++;
            total++; if (upd_we !== m_we) $display("FAIL rnd_we@%0d: got %0b exp %0b", n, upd_we, m_we); else passed++;
            total++; if (mispredict !== m_mis) $display("FAIL rnd_mis@%0d: got %0b exp %0b", n, mispredict, m_mis); else passed++;
            total++; if (upd_pc !== m_pc) $display("FAIL rnd_pc@%0d: got %0h exp %0h", n, upd_pc, m_pc); else passed++;
            total++; if (upd_history !== m_uh) $display("FAIL rnd_uhist@%0d: got %0h exp %0h", n, upd_history, m_uh); else passed++;
            total++; if (upd_taken !== m_taken) $display("FAIL rnd_taken@%0d: got %0b exp %0b", n, upd_taken, m_taken); else passed++;
        end
        idle();
`ifdef PRED_STATS_EN
        total++; if (stat_branches !== 16'(m_br)) $display("FAIL stat_br: got %0d exp %0d", stat_branches, m_br); else passed++;
        total++; if (stat_mispredicts !== 16'(m_mp)) $display("FAIL stat_mp: got %0d exp %0d", stat_mispredicts, m_mp); else passed++;
`else
        total++; if (stat_branches !== 16'd0) $display("FAIL stat_br: got %0d exp 0", stat_branches); else passed++;
        total++; if (stat_mispredicts !== 16'd0) $display("FAIL stat_mp: got %0d exp 0", stat_mispredicts); else passed++;
`endif
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_mispredict();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
